// File: rtl/mac_preact_if.sv
// mac_preact_if: command, operand-stream and result-stream signals of the pre-activation MAC.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the operand stream, out_valid/out_ready on the result.
//
// master: the upstream/downstream side (drives start, bias, operands and out_ready).
// slave : the MAC itself (drives in_ready, out_valid, out_data, sat_flag, busy).
interface mac_preact_if;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sat_flag;
    logic        busy;

    modport master (
        output start, bias, in_valid, x, w, out_ready,
        input  in_ready, out_valid, out_data, sat_flag, busy
    );

    modport slave (
        input  start, bias, in_valid, x, w, out_ready,
        output in_ready, out_valid, out_data, sat_flag, busy
    );
endinterface

// File: rtl/mac_preact.sv
// mac_preact: bias + sum(x[i]*w[i]) over LEN Q4.12 operand pairs, saturated to a Q4.12 result.
// Latency: result valid the cycle after the LEN-th accepted operand pair.
// Backpressure: in_ready only while accumulating; result held stable until out_ready.
//
// Ports: clk (rising edge), rst_n (async active-low), bus (mac_preact_if.slave):
//   start/bias begin a dot product from IDLE; x/w arrive on in_valid/in_ready;
//   out_data/sat_flag leave on out_valid/out_ready; busy is high outside IDLE.
// Build option MAC_PREACT_ROUND_EN: round half toward +inf when dropping the 12
//   fractional bits of the Q8.24 accumulator; undefined truncates toward -inf.
module mac_preact #(
    parameter int LEN   = 16,
    parameter int ACC_W = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    mac_preact_if.slave bus
);

    // A 1-bit counter still works for LEN=1: the only beat is also the last one.
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [15:0]             out_data_q, out_data_d;
    logic                    sat_q, sat_d;

    logic signed [31:0]      x_ext, w_ext, prod;
    logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_next, acc_adj, r;
    logic                    in_ready_w, beat, last_beat;
    logic                    r_fits;
    logic [15:0]             r_sat;
    logic                    r_clip;

    // Q4.12 x Q4.12 gives a Q8.24 product; 32 bits hold every 16x16 signed product.
    assign x_ext = {{16{bus.x[15]}}, bus.x};
    assign w_ext = {{16{bus.w[15]}}, bus.w};
    assign prod  = x_ext * w_ext;

    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign bias_ext = {{(ACC_W-16){bus.bias[15]}}, bus.bias};
    assign acc_next = acc_q + prod_ext;

`ifdef MAC_PREACT_ROUND_EN
    // Adding half an output LSB before the floor shift rounds half toward +inf.
    assign acc_adj = acc_next + ACC_W'(2048);
`else
    assign acc_adj = acc_next;
`endif

    assign r = acc_adj >>> 12;

    // r fits in 16 signed bits exactly when bits [ACC_W-1:15] are all copies of the sign.
    assign r_fits = (&r[ACC_W-1:15]) | ~(|r[ACC_W-1:15]);

    always_comb begin
        r_sat  = r[15:0];
        r_clip = 1'b0;
        if (!r_fits) begin
            r_clip = 1'b1;
            r_sat  = r[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    assign in_ready_w = (state_q == S_ACCUM);
    assign beat       = bus.in_valid & in_ready_w;
    assign last_beat  = (count_q == CNT_W'(LEN - 1));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Align the Q4.12 bias to the Q8.24 accumulator.
                    acc_d   = bias_ext <<< 12;
                    count_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d   = acc_next;
                    count_d = count_q + CNT_W'(1);
                    if (last_beat) begin
                        // Result comes from acc_next so out_valid follows the last beat by one cycle.
                        out_data_d = r_sat;
                        sat_d      = r_clip;
                        state_d    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                // start is deliberately not looked at here, even in the handshake cycle.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            out_data_q <= 16'h0000;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: doc/mac_preact.md
Name: mac_preact

Overview:
- Streaming multiply-accumulate stage that computes one neuron pre-activation, bias + sum(x[i]*w[i]) for i = 0..LEN-1, in Q4.12 fixed point.
- Sits directly upstream of the combinational tanh/sigmoid activation units. Its saturated 16-bit Q4.12 result drives their `in` port.
- Accepts one operand pair per cycle over a valid/ready handshake and emits one result per dot product over a valid/ready handshake.

Parameters:
- LEN, 16: operand pairs per dot product; legal range 1..1024.
- ACC_W, 40: accumulator width in bits; must be >= 32 + clog2(LEN) + 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a dot product. Honoured only in IDLE.
- bias  input  16  signed Q4.12 bias; sampled when start is accepted.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage accepts an operand pair this cycle.
- x  input  16  signed Q4.12 activation operand.
- w  input  16  signed Q4.12 weight operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  16  signed Q4.12 saturated pre-activation.
- sat_flag  output  1  result was clipped; qualified by out_valid.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, acc=0, count=0.
  - in_ready=0, out_valid=0, out_data=0x0000, sat_flag=0, busy=0.
- States: IDLE, ACCUM, OUT.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: acc <= sign_extend(bias) <<< 12 (Q8.24 alignment), count <= 0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid & in_ready.
  - Per beat: acc <= acc + sign_extend(x*w). The product is a full 32-bit signed Q8.24 value. count <= count + 1.
  - In cycles with in_valid=0: acc and count hold.
  - On the beat where count == LEN-1:
    - Result is formed from the updated accumulator value acc_next.
    - out_data and sat_flag are registered.
    - Go to OUT.
    - out_valid rises the cycle after the last accepted beat (latency 1).
- Result formation:
  - r = acc_next >>> 12 (arithmetic shift, floor). See the optional feature for rounding.
  - If r > 32767: out_data=0x7FFF, sat_flag=1.
  - If r < -32768: out_data=0x8000, sat_flag=1.
  - Otherwise: out_data=r[15:0], sat_flag=0.
- OUT:
  - out_valid=1, in_ready=0.
  - out_data and sat_flag stay stable until out_valid & out_ready.
  - After the handshake, go to IDLE; out_valid=0 the next cycle.
  - out_data keeps its last value while in IDLE.
- start outside IDLE is ignored. This includes start in the same cycle as the output handshake; the FSM is still in IDLE the following cycle.
- in_valid outside ACCUM is ignored; x and w are not consumed.
- LEN=1: a single beat goes straight to OUT.
- No internal wrap-around: ACC_W sizing guarantees the accumulator cannot overflow. Clipping happens only at the 16-bit output.
- rst_n asserted mid-operation aborts immediately to the reset state. No partial result is emitted.

Optional Feature:
- Macro: MAC_PREACT_ROUND_EN.
- Defined: r = (acc_next + 2048) >>> 12, i.e. round half toward +infinity, applied before saturation.
- Undefined: r = acc_next >>> 12 (truncate toward -infinity).
- Handshake, latency and saturation rules are identical in both builds.

Test Plan:
- Basic sum: LEN=4, bias=0x0000, four beats x=0x1000, w=0x0800 -> out_data=0x2000 (2.0), sat_flag=0; out_valid exactly 1 cycle after the 4th beat.
- Negative with bias: LEN=4, bias=0x0800, four beats x=0xF000, w=0x1000 -> out_data=0xC800 (-3.5), sat_flag=0.
- Saturation: LEN=16, bias=0x7FFF, all beats x=0x7FFF, w=0x7FFF -> out_data=0x7FFF, sat_flag=1. Repeat with w=0x8001 and bias=0x8000 -> out_data=0x8000, sat_flag=1.
- Rounding, LEN=1, bias=0:
  - x=0x0001, w=0x0800 -> 0x0001 with MAC_PREACT_ROUND_EN, 0x0000 without.
  - x=0xFFFF, w=0x0800 -> 0x0000 with, 0xFFFF without.
- Handshake stress, LEN=8:
  - Random in_valid gaps give the same result as a back-to-back stream.
  - Hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0.
  - start pulses during ACCUM/OUT are ignored.
  - A second start after return to IDLE yields a correct second result.
- Reset abort: assert rst_n=0 after 3 of 8 beats -> all outputs at reset values. A new start then gives a clean result with no residue from the aborted sum.
